// File: rtl/tm1637_pkg.sv
// Shared constants and sequencer state encoding for the TM1637 display path.
package tm1637_pkg;

    localparam logic [7:0]  TM1637_CMD_DATA_AUTOINC = 8'h40;
    localparam logic [7:0]  TM1637_CMD_ADDR_BASE    = 8'hC0;
    localparam logic [7:0]  TM1637_CMD_DISP_CTRL    = 8'h80;
    localparam int unsigned TM1637_NUM_DIGITS       = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STROBE,
        SETTLE,
        WAIT_BE,
        WAIT_SS,
        GAP,
        DONE
    } seq_state_t;

endpackage

// File: rtl/tm1637_spi_sequencer_sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous reset to a chosen level.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tm1637_spi_sequencer.sv
// Sequences the three TM1637 refresh frames (data command, address + four
// digits, display control) through an spi_master's wr/buffempty/ss handshake.
// Optional watchdog on the handshake waits: define TM1637_SEQ_TIMEOUT_EN.
module tm1637_spi_sequencer
    import tm1637_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter logic [2:0]  SPI_PRESCALLER = 3'd4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] digits,
    input  logic [2:0]  brightness,
    input  logic        display_on,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  spi_data_in,
    output logic        spi_wr,
    input  logic        spi_buffempty,
    input  logic        spi_ss,
    output logic        spi_lsbfirst,
    output logic [1:0]  spi_mode,
    output logic [2:0]  spi_prescaller
);

    localparam logic [15:0] GAP_LAST       = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST    = 16'd2;
    localparam logic [2:0]  LAST_DIGIT_IDX = 3'(TM1637_NUM_DIGITS);

    seq_state_t  state;
    logic [1:0]  frame;
    logic [2:0]  idx;
    logic [15:0] cnt;
    logic [31:0] dig_q;
    logic [2:0]  bri_q;
    logic        on_q;
    logic        be_s;
    logic        ss_s;
    logic [7:0]  cur_byte;
    logic        byte_is_last;

    assign spi_lsbfirst   = 1'b1;
    assign spi_mode       = 2'b11;
    assign spi_prescaller = SPI_PRESCALLER;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync_be (
        .clk (clk),
        .rst (rst),
        .d   (spi_buffempty),
        .q   (be_s)
    );

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync_ss (
        .clk (clk),
        .rst (rst),
        .d   (spi_ss),
        .q   (ss_s)
    );

    // Byte to transmit for the current frame/index, from the latched inputs.
    always_comb begin
        cur_byte     = '0;
        byte_is_last = 1'b1;
        case (frame)
            2'd0: cur_byte = TM1637_CMD_DATA_AUTOINC;
            2'd1: begin
                byte_is_last = (idx == LAST_DIGIT_IDX);
                case (idx)
                    3'd1:    cur_byte = dig_q[7:0];
                    3'd2:    cur_byte = dig_q[15:8];
                    3'd3:    cur_byte = dig_q[23:16];
                    3'd4:    cur_byte = dig_q[31:24];
                    default: cur_byte = TM1637_CMD_ADDR_BASE;
                endcase
            end
            default: cur_byte = TM1637_CMD_DISP_CTRL | {4'b0000, on_q, bri_q};
        endcase
    end

`ifdef TM1637_SEQ_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd;
`else
    assign error = 1'b0;
`endif

    // Refresh state machine with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            spi_wr      <= 1'b0;
            spi_data_in <= '0;
            frame       <= '0;
            idx         <= '0;
            cnt         <= '0;
            dig_q       <= '0;
            bri_q       <= '0;
            on_q        <= 1'b0;
`ifdef TM1637_SEQ_TIMEOUT_EN
            wd          <= '0;
            error       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dig_q <= digits;
                        bri_q <= brightness;
                        on_q  <= display_on;
                        busy  <= 1'b1;
                        frame <= '0;
                        idx   <= '0;
                        state <= LOAD;
`ifdef TM1637_SEQ_TIMEOUT_EN
                        error <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    spi_data_in <= cur_byte;
                    spi_wr      <= 1'b0;
                    state       <= STROBE;
                end
                STROBE: begin
                    spi_wr <= 1'b1;
                    cnt    <= '0;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    spi_wr <= 1'b0;
                    if (cnt == SETTLE_LAST) begin
                        state <= WAIT_BE;
`ifdef TM1637_SEQ_TIMEOUT_EN
                        wd    <= '0;
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_BE: begin
                    if (be_s) begin
                        if (!byte_is_last) begin
                            idx   <= idx + 3'd1;
                            state <= LOAD;
                        end else begin
                            state <= WAIT_SS;
`ifdef TM1637_SEQ_TIMEOUT_EN
                            wd    <= '0;
`endif
                        end
                    end
`ifdef TM1637_SEQ_TIMEOUT_EN
                    else if (wd == WD_LAST) begin
                        error  <= 1'b1;
                        spi_wr <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wd <= wd + 16'd1;
                    end
`endif
                end
                WAIT_SS: begin
                    if (ss_s) begin
                        cnt   <= '0;
                        state <= GAP;
                    end
`ifdef TM1637_SEQ_TIMEOUT_EN
                    else if (wd == WD_LAST) begin
                        error  <= 1'b1;
                        spi_wr <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wd <= wd + 16'd1;
                    end
`endif
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        if (frame != 2'd2) begin
                            frame <= frame + 2'd1;
                            idx   <= '0;
                            state <= LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                // done was raised on entry so busy stays high through the pulse.
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
